reaction_fsm: RTL and testbench
===============================

Name: reaction_fsm

Overview:
Control FSM for the reaction timer. It drives the start/stop pair consumed by the LED controller. It debounces the two DE10-Lite push-buttons and waits a pseudo-random delay before asserting start (LEDs on). It then counts milliseconds until the player presses stop (LEDs off) and reports the reaction time, or flags a false start.

Parameters:
TICK_DIV, 50000, clk cycles per 1 ms tick (50 MHz board clock)
DEBOUNCE_CYCLES, 500000, consecutive stable synced samples needed to accept a press (10 ms)
MIN_DELAY_MS, 1000, minimum random wait in ms
DELAY_BITS, 11, LFSR bits added to MIN_DELAY_MS (random range 0..2^DELAY_BITS-1 ms)
MAX_MS, 9999, reaction count saturation / timeout value

Ports:
clk  input  1  board clock
rst  input  1  asynchronous active-high reset
key_start_n  input  1  raw start button, active-low, asynchronous to clk
key_stop_n  input  1  raw stop button, active-low, asynchronous to clk
start  output  1  high only in TIMING; drives LED controller start
stop  output  1  high in DONE or FOUL; drives LED controller stop
reaction_ms  output  14  measured reaction time in ms, held until next round
valid  output  1  high in DONE (reaction_ms meaningful)
foul  output  1  high in FOUL (stop pressed before start)
timeout  output  1  high in DONE when count reached MAX_MS without a stop press
busy  output  1  high in WAIT_RAND or TIMING

Behaviour:
- Reset: asynchronous active-high. State IDLE. All outputs 0, reaction_ms=0. LFSR=16'hACE1. Tick, delay and debounce counters = 0. Debounce filters hold the "released" level. Reset mid-round aborts immediately with no further pulses.
- Input path, per key: 2-FF synchroniser, then debounce counter.
  - The filtered level changes only after DEBOUNCE_CYCLES consecutive synced samples differ from the current filtered level.
  - Press pulse = 1-cycle registered pulse on the filtered released->pressed transition.
  - Release generates nothing. A held key yields one pulse only.
- LFSR: 16-bit Fibonacci, advances every clk.
  - Feedback = l[15]^l[13]^l[12]^l[10], shifted into bit 0 (shift left).
  - Never zero.
- ms tick: tick counter runs 0..TICK_DIV-1. Tick pulse when the counter equals TICK_DIV-1, then the counter wraps to 0. The counter is cleared on every entry to WAIT_RAND and TIMING.
- States and transitions (evaluated on the clock edge where the press pulse is high):
  - IDLE: start press -> WAIT_RAND. Stop press ignored.
  - WAIT_RAND:
    - On entry, delay_ms = MIN_DELAY_MS + lfsr[DELAY_BITS-1:0], using the LFSR value in the cycle the start pulse is high.
    - Each tick decrements delay_ms. The tick that brings it to 0 -> TIMING.
    - Stop press -> FOUL; this takes priority over a coincident final tick.
    - Start press ignored.
  - TIMING:
    - reaction_ms cleared to 0 on entry; +1 per tick.
    - Stop press -> DONE; reaction_ms keeps its current value, and a coincident tick is not counted.
    - The tick that makes reaction_ms==MAX_MS -> DONE with timeout=1.
    - Start press ignored.
  - DONE: start press -> WAIT_RAND and clears reaction_ms, valid and timeout. Stop press ignored.
  - FOUL: start press -> WAIT_RAND and clears foul. Stop press ignored.
- Outputs are registered and decoded from state. They change in the same edge as the state transition, i.e. the cycle after the press pulse.
- start and stop are never high together.
- Width rules: reaction_ms saturates at MAX_MS and never wraps. delay_ms needs ceil(log2(MIN_DELAY_MS+2^DELAY_BITS)) bits.
- Simultaneous start and stop pulses: the state's own rules apply. In IDLE, DONE and FOUL start wins; in WAIT_RAND and TIMING stop wins.

Test Plan:
Bench params: TICK_DIV=4, DEBOUNCE_CYCLES=3, MIN_DELAY_MS=5, DELAY_BITS=3, MAX_MS=20; the bench models the LFSR.

1. Reset held, keys toggling -> all outputs 0, state IDLE. Release reset, no keys -> outputs stay 0 for 200 cycles.
2. Bounce key_start_n low/high in runs of 1-2 cycles, then hold low 10 cycles -> exactly one press pulse, busy=1. start rises after exactly (5+lfsr[2:0])*4 cycles from the entry edge.
3. Full round: after start=1, wait 7 ticks (28 cycles), press stop -> stop=1, start=0, valid=1, reaction_ms=7 held. A second stop press -> no change.
4. False start: press stop during WAIT_RAND -> foul=1, stop=1, start never asserted, reaction_ms=0. Then press start -> foul=0, busy=1.
5. Timeout: enter TIMING with no stop -> after 20 ticks (80 cycles) valid=1, timeout=1, reaction_ms=20, stop=1.
6. Assert rst mid-TIMING at reaction_ms=3 -> same cycle all outputs 0. After release, IDLE requires a new start press.

Source files
------------

// File: rtl/reaction_fsm.sv
// Reaction-timer control: debounced keys, pseudo-random pre-start wait,
// millisecond reaction count with timeout and false-start detection.

module reaction_fsm_key #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // level_q is the accepted level, 1 = pressed; the counter holds how many
  // consecutive synced samples have disagreed with it so far.
  always_comb begin
    meta_d  = key_n;
    sync_d  = meta_q;
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (~sync_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
        press_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;
endmodule

module reaction_fsm #(
  parameter int TICK_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MIN_DELAY_MS    = 1000,
  parameter int DELAY_BITS      = 11,
  parameter int MAX_MS          = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_start_n,
  input  logic        key_stop_n,
  output logic        start,
  output logic        stop,
  output logic [13:0] reaction_ms,
  output logic        valid,
  output logic        foul,
  output logic        timeout,
  output logic        busy
);
  localparam int DW = $clog2(MIN_DELAY_MS + (1 << DELAY_BITS));
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] MIN_DELAY = DW'(MIN_DELAY_MS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RAND,
    S_TIMING,
    S_DONE,
    S_FOUL
  } state_t;

  logic start_press, stop_press;

  reaction_fsm_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_start (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_start_n),
    .press (start_press)
  );

  reaction_fsm_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_stop (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_stop_n),
    .press (stop_press)
  );

  state_t        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [DW-1:0] delay_q, delay_d;
  logic [13:0]   react_q, react_d;
  logic          timeout_q, timeout_d;
  logic          start_q, start_d;
  logic          stop_q, stop_d;
  logic          valid_q, valid_d;
  logic          foul_q, foul_d;
  logic          busy_q, busy_d;
  logic          tick;
  logic          new_round;

  always_comb begin
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    state_d    = state_q;
    delay_d    = delay_q;
    react_d    = react_q;
    timeout_d  = timeout_q;
    new_round  = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_FOUL: begin
        new_round = start_press;
      end
      S_WAIT_RAND: begin
        if (stop_press) begin
          state_d = S_FOUL;
        end else if (tick) begin
          if (delay_q <= DW'(1)) begin
            state_d    = S_TIMING;
            delay_d    = '0;
            react_d    = '0;
            tick_cnt_d = '0;
          end else begin
            delay_d = delay_q - DW'(1);
          end
        end
      end
      S_TIMING: begin
        // A stop press freezes the count, even against a coincident tick.
        if (stop_press) begin
          state_d = S_DONE;
        end else if (tick && (react_q < 14'(MAX_MS))) begin
          react_d = react_q + 14'd1;
          if (react_q == 14'(MAX_MS - 1)) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (new_round) begin
      state_d    = S_WAIT_RAND;
      delay_d    = MIN_DELAY + DW'(lfsr_q[DELAY_BITS-1:0]);
      react_d    = '0;
      timeout_d  = 1'b0;
      tick_cnt_d = '0;
    end

    start_d = (state_d == S_TIMING);
    stop_d  = (state_d == S_DONE) || (state_d == S_FOUL);
    valid_d = (state_d == S_DONE);
    foul_d  = (state_d == S_FOUL);
    busy_d  = (state_d == S_WAIT_RAND) || (state_d == S_TIMING);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lfsr_q     <= 16'hACE1;
      tick_cnt_q <= '0;
      delay_q    <= '0;
      react_q    <= '0;
      timeout_q  <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      valid_q    <= 1'b0;
      foul_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      tick_cnt_q <= tick_cnt_d;
      delay_q    <= delay_d;
      react_q    <= react_d;
      timeout_q  <= timeout_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      valid_q    <= valid_d;
      foul_q     <= foul_d;
      busy_q     <= busy_d;
    end
  end

  assign start       = start_q;
  assign stop        = stop_q;
  assign reaction_ms = react_q;
  assign valid       = valid_q;
  assign foul        = foul_q;
  assign timeout     = timeout_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_reaction_fsm.sv
// Bench for reaction_fsm: cycle-level behavioural model compared every cycle,
// plus directed literal checks for latency, reaction count, foul and timeout.
module tb_reaction_fsm;
  localparam int TICK_DIV = 4;
  localparam int DEB      = 3;
  localparam int MIN_D    = 5;
  localparam int DBITS    = 3;
  localparam int MAX_MS   = 20;

  localparam int M_IDLE = 0, M_WAIT = 1, M_TIME = 2, M_DONE = 3, M_FOUL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_start_n = 1'b1;
  logic key_stop_n = 1'b1;
  logic start, stop, valid, foul, timeout, busy;
  logic [13:0] reaction_ms;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  reaction_fsm #(
    .TICK_DIV(TICK_DIV), .DEBOUNCE_CYCLES(DEB), .MIN_DELAY_MS(MIN_D),
    .DELAY_BITS(DBITS), .MAX_MS(MAX_MS)
  ) dut (
    .clk(clk), .rst(rst), .key_start_n(key_start_n), .key_stop_n(key_stop_n),
    .start(start), .stop(stop), .reaction_ms(reaction_ms), .valid(valid),
    .foul(foul), .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: index 0 = start key, 1 = stop key.
  int          m_mode, m_wait_left, m_count, m_since;
  bit          m_timeout;
  logic [15:0] m_lfsr, m_entry_lfsr;
  bit          m_h0[2], m_h1[2], m_lvl[2], m_pulse[2];
  int          m_run[2];

  task automatic model_reset();
    m_mode = M_IDLE; m_wait_left = 0; m_count = 0; m_since = 0;
    m_timeout = 1'b0; m_lfsr = 16'hACE1;
    for (int k = 0; k < 2; k++) begin
      m_h0[k] = 1'b1; m_h1[k] = 1'b1; m_lvl[k] = 1'b0; m_run[k] = 0; m_pulse[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit tick, entered, s, raw_now;
    tick = (m_mode == M_WAIT || m_mode == M_TIME) && (m_since % TICK_DIV == TICK_DIV - 1);
    entered = 1'b0;
    case (m_mode)
      M_IDLE, M_DONE, M_FOUL:
        if (m_pulse[0]) begin
          m_mode = M_WAIT; m_wait_left = MIN_D + int'(m_lfsr % (1 << DBITS));
          m_entry_lfsr = m_lfsr; m_count = 0; m_timeout = 1'b0; entered = 1'b1;
        end
      M_WAIT:
        if (m_pulse[1]) m_mode = M_FOUL;
        else if (tick) begin
          m_wait_left--;
          if (m_wait_left == 0) begin m_mode = M_TIME; m_count = 0; entered = 1'b1; end
        end
      M_TIME:
        if (m_pulse[1]) m_mode = M_DONE;
        else if (tick) begin
          m_count++;
          if (m_count == MAX_MS) begin m_mode = M_DONE; m_timeout = 1'b1; end
        end
      default: m_mode = M_IDLE;
    endcase
    m_since = entered ? 0 : m_since + 1;
    for (int k = 0; k < 2; k++) begin
      raw_now = (k == 0) ? key_start_n : key_stop_n;
      s = ~m_h1[k];
      m_h1[k] = m_h0[k];
      m_h0[k] = raw_now;
      m_pulse[k] = 1'b0;
      if (s != m_lvl[k]) begin
        m_run[k]++;
        if (m_run[k] == DEB) begin
          m_lvl[k] = s; m_run[k] = 0; m_pulse[k] = s;
        end
      end else begin
        m_run[k] = 0;
      end
    end
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endtask

  function automatic logic [19:0] model_out();
    return {m_mode == M_TIME, m_mode == M_DONE || m_mode == M_FOUL, m_mode == M_DONE,
            m_mode == M_FOUL, m_mode == M_DONE && m_timeout,
            m_mode == M_WAIT || m_mode == M_TIME, 14'(m_count)};
  endfunction

  initial model_reset();

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({start, stop, valid, foul, timeout, busy, reaction_ms} !== model_out()) begin
        errors++;
        $display("[TB] FAIL model_compare t=%0t got start=%b stop=%b valid=%b foul=%b timeout=%b busy=%b ms=%0d expected %h",
                 $time, start, stop, valid, foul, timeout, busy, reaction_ms, model_out());
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input int key, input int hold);
    if (key == 0) key_start_n = 1'b0; else key_stop_n = 1'b0;
    step(hold);
    key_start_n = 1'b1;
    key_stop_n  = 1'b1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({start, stop, valid, foul, timeout, busy, reaction_ms});
  endfunction

  int bounce[6] = '{1, 1, 2, 2, 1, 2};
  int n;

  initial begin
    step(2);
    chk_en = 1'b1;

    $display("[TB] reset with toggling keys");
    for (int i = 0; i < 12; i++) begin
      key_start_n = i[0];
      key_stop_n  = ~i[1];
      step(1);
    end
    checkOutput("reset_outputs", all_outs(), 0);
    key_start_n = 1'b1; key_stop_n = 1'b1;
    step(2);
    rst = 1'b0;
    step(200);
    checkOutput("idle_200_cycles", all_outs(), 0);

    $display("[TB] bounced start press");
    for (int i = 0; i < 6; i++) begin
      key_start_n = i[0];
      step(bounce[i]);
    end
    checkOutput("no_press_from_bounce", busy, 0);
    key_start_n = 1'b0;
    n = 0;
    while (!busy && n < 20) begin step(1); n++; end
    checkOutput("press_to_busy_cycles", n, 6);
    checkOutput("start_low_in_wait", start, 0);
    n = 0;
    while (!start && n < 100) begin
      if (n == 4) key_start_n = 1'b1;
      step(1); n++;
    end
    key_start_n = 1'b1;
    checkOutput("start_delay_cycles", n, (MIN_D + int'(m_entry_lfsr[2:0])) * TICK_DIV);

    $display("[TB] full round");
    step(24);
    applyStimulus(1, 8);
    checkOutput("round_stop", stop, 1);
    checkOutput("round_start", start, 0);
    checkOutput("round_valid", valid, 1);
    checkOutput("round_reaction_ms", reaction_ms, 7);
    step(8);
    applyStimulus(1, 8);
    step(10);
    checkOutput("second_stop_reaction_ms", reaction_ms, 7);
    checkOutput("second_stop_valid", valid, 1);

    $display("[TB] false start");
    applyStimulus(0, 8);
    checkOutput("new_round_busy", busy, 1);
    checkOutput("new_round_cleared_ms", reaction_ms, 0);
    applyStimulus(1, 8);
    checkOutput("foul_flag", foul, 1);
    checkOutput("foul_stop", stop, 1);
    checkOutput("foul_start", start, 0);
    checkOutput("foul_reaction_ms", reaction_ms, 0);
    step(8);
    applyStimulus(0, 8);
    checkOutput("foul_cleared", foul, 0);
    checkOutput("foul_restart_busy", busy, 1);

    $display("[TB] timeout");
    n = 0;
    while (!start && n < 100) begin step(1); n++; end
    checkOutput("timeout_start_seen", start, 1);
    n = 0;
    while (!valid && n < 200) begin step(1); n++; end
    checkOutput("timeout_cycles", n, MAX_MS * TICK_DIV);
    checkOutput("timeout_flag", timeout, 1);
    checkOutput("timeout_reaction_ms", reaction_ms, MAX_MS);
    checkOutput("timeout_stop", stop, 1);

    $display("[TB] reset mid-timing");
    applyStimulus(0, 8);
    n = 0;
    while (!start && n < 100) begin step(1); n++; end
    n = 0;
    while (reaction_ms != 14'd3 && n < 40) begin step(1); n++; end
    checkOutput("mid_timing_ms", reaction_ms, 3);
    rst = 1'b1;
    #1;
    checkOutput("async_reset_outputs", all_outs(), 0);
    step(2);
    rst = 1'b0;
    step(50);
    checkOutput("idle_after_reset", all_outs(), 0);
    applyStimulus(0, 8);
    checkOutput("new_press_after_reset", busy, 1);
    step(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
